// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch front end: FSM encodings,
// PC increment and counter sizing.
`timescale 1ns/1ps
package fetch_pkg;

    localparam logic [1:0] ST_RST_WAIT = 2'd0;
    localparam logic [1:0] ST_FETCH    = 2'd1;
    localparam logic [1:0] ST_DROP     = 2'd2;

    localparam int unsigned PC_INC = 4;

    // Counters must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int fetch_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched instructions: entries are allocated when a request
// fires, filled in request order by responses, and popped from the head.
`timescale 1ns/1ps
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = fetch_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alloc,
    input  logic [ADDR_W-1:0] alloc_pc,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_instr,
    output logic [CNT_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  inflight
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [DEPTH-1:0]   filled_q, filled_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W-1:0]   fptr_q, fptr_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   infl_q, infl_d;
    logic               fill_ok;

    assign fill_ok = fill && (infl_q != '0);

    always_comb begin
        ent_d    = ent_q;
        filled_d = filled_q;
        head_d   = head_q;
        tail_d   = tail_q;
        fptr_d   = fptr_q;
        occ_d    = occ_q + CNT_W'(alloc) - CNT_W'(pop);
        infl_d   = infl_q + CNT_W'(alloc) - CNT_W'(fill_ok);

        // A full buffer may alloc into the slot being popped; the head is read
        // from registers, so the outgoing entry is unaffected.
        if (alloc) begin
            ent_d[tail_q].pc  = alloc_pc;
            filled_d[tail_q]  = 1'b0;
            tail_d            = tail_q + PTR_W'(1);
        end
        if (fill_ok) begin
            ent_d[fptr_q].instr = fill_data;
            filled_d[fptr_q]    = 1'b1;
            fptr_d              = fptr_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end

        if (flush) begin
            filled_d = '0;
            head_d   = '0;
            tail_d   = '0;
            fptr_d   = '0;
            occ_d    = '0;
            infl_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filled_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            fptr_q   <= '0;
            occ_q    <= '0;
            infl_q   <= '0;
        end else begin
            filled_q <= filled_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            fptr_q   <= fptr_d;
            occ_q    <= occ_d;
            infl_q   <= infl_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign head_valid = (occ_q != '0) && filled_q[head_q];
    assign head_pc    = ent_q[head_q].pc;
    assign head_instr = ent_q[head_q].instr;
    assign occupancy  = occ_q;
    assign inflight   = infl_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order memory requests,
// buffers returned instructions and discards responses made stale by redirects.
`timescale 1ns/1ps
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4
);

    localparam int CNT_W = fetch_cnt_w(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              head_valid;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_instr;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W-1:0]  inflight;
    logic              pop;
    logic              req_fire;
    logic              rsp_drop;
    logic              rsp_fill;

    assign pop = head_valid && if_ready;

    // A pop in this cycle frees a slot, so a full buffer can still issue.
    assign imem_req_valid = (state_q != ST_RST_WAIT) &&
                            ((occupancy < CNT_W'(DEPTH)) || pop);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = redirect_valid || (state_q == ST_DROP);
    assign rsp_fill = imem_rsp_valid && !rsp_drop;

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        state_d    = state_q;

        if (redirect_valid) begin
            pc_d       = redirect_pc & ~ADDR_W'(3);
            drop_cnt_d = drop_cnt_q + inflight + CNT_W'(req_fire);
        end else if (req_fire) begin
            pc_d = pc_q + ADDR_W'(PC_INC);
        end

        if (imem_rsp_valid && rsp_drop && (drop_cnt_d != '0)) begin
            drop_cnt_d = drop_cnt_d - CNT_W'(1);
        end

        case (state_q)
            ST_RST_WAIT: state_d = ST_FETCH;
            default:     state_d = (drop_cnt_d != '0) ? ST_DROP : ST_FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q       <= RESET_PC;
            state_q    <= ST_RST_WAIT;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk        (Clk),
        .rst_n      (Reset),
        .flush      (redirect_valid),
        .alloc      (req_fire),
        .alloc_pc   (pc_q),
        .fill       (rsp_fill),
        .fill_data  (imem_rsp_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .occupancy  (occupancy),
        .inflight   (inflight)
    );

    assign if_valid    = head_valid;
    assign if_instr    = head_valid ? head_instr : '0;
    assign if_pc       = head_valid ? head_pc : '0;
    assign if_pc_plus4 = if_pc + ADDR_W'(PC_INC);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table against a
// fixed-latency in-order memory model, then reset and scoreboard sequences.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam logic [31:0] RPC = 32'h100;
    localparam logic [31:0] NA  = 32'h1;   // address don't-care (never word aligned)

    logic        Clk = 1'b0;
    logic        Reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    always #5 Clk = ~Clk;

    if_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (RPC)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        int          lat;
        logic        chk;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    vec_t  tbl[$];
    pend_t pend[$];
    int    cyc = 0;
    int    cur_lat = 1;
    int    n_chk = 0;
    int    n_err = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5C3_5A3C;
    endfunction

    task automatic check(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %h, expected %h", nm, row, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic chk, input logic erv, input logic [31:0] ea,
                       input logic eiv, input logic [31:0] ep);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.rv = rv; t.rpc = rpc; t.lat = cur_lat;
        t.chk = chk; t.e_rv = erv; t.e_addr = ea; t.e_iv = eiv; t.e_pc = ep;
        tbl.push_back(t);
    endtask

    task automatic row(input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic erv, input logic [31:0] ea, input logic eiv, input logic [31:0] ep);
        add(1'b1, rdy, rv, rpc, 1'b1, erv, ea, eiv, ep);
    endtask

    task automatic add_reset();
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, NA, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, RPC, 1'b0, 32'h0);
    endtask

    // Drive one cycle's inputs (called just after a falling edge), then settle.
    task automatic step(input logic rst, input logic rdy, input logic rq, input logic rv, input logic [31:0] rpc);
        Reset          = rst;
        if_ready       = rdy;
        imem_req_ready = rq;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (!rst) pend.delete();
        if (rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic finish_cycle(input int lat);
        logic        fire;
        logic [31:0] a;
        fire = imem_req_valid && imem_req_ready;
        a    = imem_req_addr;
        @(posedge Clk);
        if (fire && Reset) pend.push_back('{a, cyc + lat});
        cyc++;
        @(negedge Clk);
    endtask

    task automatic check_row(input int i, input vec_t r);
        check("req_valid", i, 32'(imem_req_valid), 32'(r.e_rv));
        if (r.e_addr != NA) check("req_addr", i, imem_req_addr, r.e_addr);
        check("if_valid", i, 32'(if_valid), 32'(r.e_iv));
        if (r.e_iv || !r.rst) begin
            check("if_pc", i, if_pc, r.e_pc);
            check("if_pc_plus4", i, if_pc_plus4, r.e_pc + 32'd4);
            check("if_instr", i, if_instr, r.e_iv ? instr_of(r.e_pc) : 32'h0);
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          pops;
        logic        rdy;
        logic        got;

        Reset = 1'b0; if_ready = 1'b1; imem_req_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

        // Basic streaming, latency 1.
        cur_lat = 1;
        add_reset();
        row(1, 0, 0, 0, RPC,    0, 0);
        row(1, 0, 0, 1, 'h100, 0, 0);
        row(1, 0, 0, 1, 'h104, 0, 0);
        row(1, 0, 0, 1, 'h108, 1, 'h100);
        row(1, 0, 0, 1, 'h10C, 1, 'h104);
        row(1, 0, 0, 1, 'h110, 1, 'h108);
        row(1, 0, 0, 1, 'h114, 1, 'h10C);

        // Backpressure fills the buffer, latency 2.
        cur_lat = 2;
        add_reset();
        row(0, 0, 0, 0, RPC,    0, 0);
        row(0, 0, 0, 1, 'h100, 0, 0);
        row(0, 0, 0, 1, 'h104, 0, 0);
        row(0, 0, 0, 1, 'h108, 0, 0);
        row(0, 0, 0, 1, 'h10C, 1, 'h100);
        row(0, 0, 0, 0, 'h110, 1, 'h100);
        row(0, 0, 0, 0, 'h110, 1, 'h100);
        row(0, 0, 0, 0, 'h110, 1, 'h100);
        row(1, 0, 0, 1, 'h110, 1, 'h100);
        row(1, 0, 0, 1, 'h114, 1, 'h104);
        row(1, 0, 0, 1, 'h118, 1, 'h108);
        row(1, 0, 0, 1, 'h11C, 1, 'h10C);
        row(1, 0, 0, 1, 'h120, 1, 'h110);
        row(1, 0, 0, 1, 'h124, 1, 'h114);

        // Redirect with three stale requests, latency 3.
        cur_lat = 3;
        add_reset();
        row(1, 0, 0,      0, RPC,    0, 0);
        row(1, 0, 0,      1, 'h100, 0, 0);
        row(1, 0, 0,      1, 'h104, 0, 0);
        row(1, 1, 'h400, 1, 'h108, 0, 0);
        row(1, 0, 0,      1, 'h400, 0, 0);
        row(1, 0, 0,      1, 'h404, 0, 0);
        row(1, 0, 0,      1, 'h408, 0, 0);
        row(1, 0, 0,      1, 'h40C, 0, 0);
        row(1, 0, 0,      1, 'h410, 1, 'h400);
        row(1, 0, 0,      1, 'h414, 1, 'h404);
        row(1, 0, 0,      1, 'h418, 1, 'h408);

        // Redirect coincident with a response and a request fire.
        add_reset();
        row(1, 0, 0,      0, RPC,    0, 0);
        row(1, 0, 0,      1, 'h100, 0, 0);
        row(1, 0, 0,      1, 'h104, 0, 0);
        row(1, 0, 0,      1, 'h108, 0, 0);
        row(1, 1, 'h600, 1, 'h10C, 0, 0);
        row(1, 0, 0,      1, 'h600, 0, 0);
        row(1, 0, 0,      1, 'h604, 0, 0);
        row(1, 0, 0,      1, 'h608, 0, 0);
        row(1, 0, 0,      1, 'h60C, 0, 0);
        row(1, 0, 0,      1, 'h610, 1, 'h600);
        row(1, 0, 0,      1, 'h614, 1, 'h604);

        // Second redirect while still dropping.
        add_reset();
        row(1, 0, 0,      0, RPC,    0, 0);
        row(1, 0, 0,      1, 'h100, 0, 0);
        row(1, 0, 0,      1, 'h104, 0, 0);
        row(1, 1, 'h400, 1, 'h108, 0, 0);
        row(1, 0, 0,      1, 'h400, 0, 0);
        row(1, 1, 'h800, 1, 'h404, 0, 0);
        row(1, 0, 0,      1, 'h800, 0, 0);
        row(1, 0, 0,      1, 'h804, 0, 0);
        row(1, 0, 0,      1, 'h808, 0, 0);
        row(1, 0, 0,      1, 'h80C, 0, 0);
        row(1, 0, 0,      1, 'h810, 1, 'h800);
        row(1, 0, 0,      1, 'h814, 1, 'h804);

        // Unaligned redirect target and address wrap, latency 1.
        cur_lat = 1;
        add_reset();
        row(1, 0, 0,            0, RPC,          0, 0);
        row(1, 1, 'h403,       1, 'h100,       0, 0);
        row(1, 0, 0,            1, 'h400,       0, 0);
        row(1, 0, 0,            1, 'h404,       0, 0);
        row(1, 1, 'hFFFF_FFF8, 1, 'h408,       1, 'h400);
        row(1, 0, 0,            1, 'hFFFF_FFF8, 0, 0);
        row(1, 0, 0,            1, 'hFFFF_FFFC, 0, 0);
        row(1, 0, 0,            1, 'h0,         1, 'hFFFF_FFF8);
        row(1, 0, 0,            1, 'h4,         1, 'hFFFF_FFFC);
        row(1, 0, 0,            1, 'h8,         1, 'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].rdy, 1'b1, tbl[i].rv, tbl[i].rpc);
            if (tbl[i].chk) check_row(i, tbl[i]);
            finish_cycle(tbl[i].lat);
        end

        // Reset asserted while the pipeline is busy.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        finish_cycle(2);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("mid_rst_req_valid", -1, 32'(imem_req_valid), 32'h0);
        check("mid_rst_req_addr",  -1, imem_req_addr, RPC);
        check("mid_rst_if_valid",  -1, 32'(if_valid), 32'h0);
        check("mid_rst_if_instr",  -1, if_instr, 32'h0);
        check("mid_rst_if_pc",     -1, if_pc, 32'h0);
        check("mid_rst_pc_plus4",  -1, if_pc_plus4, 32'h4);
        finish_cycle(2);

        // Random consumer and memory stalls; output stream must stay in PC order.
        exp_pc = RPC;
        pops   = 0;
        for (int i = 0; i < 80; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            step(1'b1, rdy, ($urandom_range(0, 4) != 0), 1'b0, 32'h0);
            if (if_valid && rdy) begin
                check("sb_if_pc",    -2, if_pc, exp_pc);
                check("sb_if_instr", -2, if_instr, instr_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            finish_cycle(2);
        end
        check("sb_throughput", -2, 32'(pops > 20), 32'h1);

        // Redirect out of a random state; a pop in the redirect cycle still completes.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h2000);
        if (if_valid) begin
            check("redir_cycle_pop_pc", -3, if_pc, exp_pc);
        end
        finish_cycle(2);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (if_valid) begin
                got = 1'b1;
                check("redir_first_pc",    -3, if_pc, 32'h2000);
                check("redir_first_instr", -3, if_instr, instr_of(32'h2000));
            end
            finish_cycle(2);
        end
        if (!got) check("redir_timeout", -3, 32'h0, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
